// File: rtl/ghist_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ghist_queue_ctrl
// Brief    : In-order slot allocator / reader for the global-history snapshot
//            memory; optional occupancy stats under GHIST_OCC_STATS_EN.
// Revision : 1.0
// ============================================================================
module ghist_queue_ctrl #(
    parameter int DEPTH  = 40,
    parameter int IDX_W  = 6,
    parameter int DATA_W = 72
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_enq_valid,
    output logic              io_enq_ready,
    input  logic [DATA_W-1:0] io_enq_data,
    output logic [IDX_W-1:0]  io_enq_idx,
    input  logic              io_deq_valid,
    input  logic              io_redirect_valid,
    input  logic [IDX_W-1:0]  io_redirect_idx,
    input  logic              io_rd_valid,
    input  logic [IDX_W-1:0]  io_rd_idx,
    output logic              io_rd_resp_valid,
    output logic [DATA_W-1:0] io_rd_resp_data,
    output logic              io_empty,
    output logic              io_full,
`ifdef GHIST_OCC_STATS_EN
    output logic [5:0]        io_count,
    output logic [5:0]        io_hiwater,
`endif
    output logic [IDX_W-1:0]  mem_R0_addr,
    output logic              mem_R0_en,
    input  logic [DATA_W-1:0] mem_R0_data,
    output logic [IDX_W-1:0]  mem_W0_addr,
    output logic              mem_W0_en,
    output logic [DATA_W-1:0] mem_W0_data
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OFF_W = IDX_W + 1;

    function automatic logic [IDX_W-1:0] inc_ptr(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(DEPTH - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    logic [IDX_W-1:0] enq_ptr;
    logic [IDX_W-1:0] deq_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             resp_v;
    logic             enq_fire;
    logic             deq_fire;
    logic [IDX_W-1:0] deq_next;
    logic [OFF_W-1:0] redir_sum;
    logic [OFF_W-1:0] redir_off;

    assign io_empty     = (count == '0);
    assign io_full      = (count == CNT_W'(DEPTH));
    assign io_enq_ready = !io_full && !io_redirect_valid;
    assign io_enq_idx   = enq_ptr;
    assign enq_fire     = io_enq_valid && io_enq_ready;
    assign deq_fire     = io_deq_valid && !io_empty;
    assign deq_next     = deq_fire ? inc_ptr(deq_ptr) : deq_ptr;

    // Distance from the oldest surviving entry to the redirect target, mod DEPTH
    assign redir_sum = {1'b0, io_redirect_idx} + OFF_W'(DEPTH) - {1'b0, deq_next};
    assign redir_off = (redir_sum >= OFF_W'(DEPTH)) ? redir_sum - OFF_W'(DEPTH) : redir_sum;

    assign mem_R0_addr      = io_rd_idx;
    assign mem_R0_en        = io_rd_valid;
    assign mem_W0_addr      = enq_ptr;
    assign mem_W0_en        = enq_fire;
    assign mem_W0_data      = io_enq_data;
    assign io_rd_resp_valid = resp_v;
    assign io_rd_resp_data  = mem_R0_data;

    always_comb begin
        count_next = count;
        if (io_redirect_valid)
            count_next = CNT_W'(redir_off + OFF_W'(1));
        else if (enq_fire && !deq_fire)
            count_next = count + CNT_W'(1);
        else if (!enq_fire && deq_fire)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enq_ptr <= '0;
            deq_ptr <= '0;
            count   <= '0;
            resp_v  <= 1'b0;
        end else begin
            if (io_redirect_valid)
                enq_ptr <= inc_ptr(io_redirect_idx);
            else if (enq_fire)
                enq_ptr <= inc_ptr(enq_ptr);
            deq_ptr <= deq_next;
            count   <= count_next;
            resp_v  <= io_rd_valid;
        end
    end

`ifdef GHIST_OCC_STATS_EN
    logic [CNT_W-1:0] hiwater;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            hiwater <= '0;
        else if (count_next > hiwater)
            hiwater <= count_next;
    end

    assign io_count   = 6'(count);
    assign io_hiwater = 6'(hiwater);
`endif

`ifndef SYNTHESIS
    // Redirect target must be a live entry once this cycle's dequeue is applied
    logic [CNT_W-1:0] live_after_deq;
    assign live_after_deq = count - CNT_W'(deq_fire);

    always @(posedge clock) begin
        if (!reset && io_redirect_valid)
            assert ((io_redirect_idx < IDX_W'(DEPTH)) &&
                    (redir_off < OFF_W'(live_after_deq)));
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ghist_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ghist_queue_ctrl
// Brief    : Directed self-checking bench for ghist_queue_ctrl with a
//            behavioural snapshot memory attached to the R0/W0 ports.
// Revision : 1.0
// ============================================================================
module tb_ghist_queue_ctrl;

    localparam int DEPTH  = 40;
    localparam int IDX_W  = 6;
    localparam int DATA_W = 72;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              io_enq_valid = 1'b0;
    logic              io_enq_ready;
    logic [DATA_W-1:0] io_enq_data = '0;
    logic [IDX_W-1:0]  io_enq_idx;
    logic              io_deq_valid = 1'b0;
    logic              io_redirect_valid = 1'b0;
    logic [IDX_W-1:0]  io_redirect_idx = '0;
    logic              io_rd_valid = 1'b0;
    logic [IDX_W-1:0]  io_rd_idx = '0;
    logic              io_rd_resp_valid;
    logic [DATA_W-1:0] io_rd_resp_data;
    logic              io_empty;
    logic              io_full;
`ifdef GHIST_OCC_STATS_EN
    logic [5:0]        io_count;
    logic [5:0]        io_hiwater;
`endif
    logic [IDX_W-1:0]  mem_R0_addr;
    logic              mem_R0_en;
    logic [DATA_W-1:0] mem_R0_data;
    logic [IDX_W-1:0]  mem_W0_addr;
    logic              mem_W0_en;
    logic [DATA_W-1:0] mem_W0_data;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    ghist_queue_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
        .clock             (clock),
        .reset             (reset),
        .io_enq_valid      (io_enq_valid),
        .io_enq_ready      (io_enq_ready),
        .io_enq_data       (io_enq_data),
        .io_enq_idx        (io_enq_idx),
        .io_deq_valid      (io_deq_valid),
        .io_redirect_valid (io_redirect_valid),
        .io_redirect_idx   (io_redirect_idx),
        .io_rd_valid       (io_rd_valid),
        .io_rd_idx         (io_rd_idx),
        .io_rd_resp_valid  (io_rd_resp_valid),
        .io_rd_resp_data   (io_rd_resp_data),
        .io_empty          (io_empty),
        .io_full           (io_full),
`ifdef GHIST_OCC_STATS_EN
        .io_count          (io_count),
        .io_hiwater        (io_hiwater),
`endif
        .mem_R0_addr       (mem_R0_addr),
        .mem_R0_en         (mem_R0_en),
        .mem_R0_data       (mem_R0_data),
        .mem_W0_addr       (mem_W0_addr),
        .mem_W0_en         (mem_W0_en),
        .mem_W0_data       (mem_W0_data)
    );

    // Memory latches the read address and writes on the same edge
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [IDX_W-1:0]  raddr = '0;
    always @(posedge clock) begin
        if (mem_W0_en) mem[mem_W0_addr] <= mem_W0_data;
        if (mem_R0_en) raddr <= mem_R0_addr;
    end
    assign mem_R0_data = mem[raddr];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        io_enq_valid      = 1'b0;
        io_deq_valid      = 1'b0;
        io_redirect_valid = 1'b0;
        io_rd_valid       = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic enq_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            io_enq_valid = 1'b1;
            io_enq_data  = DATA_W'(base + i);
            tick();
        end
        io_enq_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        reset = 1'b0;
        #1;
        vectors++; if (io_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b exp 1", io_empty); end
        vectors++; if (io_full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b exp 0", io_full); end
        vectors++; if (io_enq_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", io_enq_ready); end
        vectors++; if (io_rd_resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid got %b exp 0", io_rd_resp_valid); end
        vectors++; if (io_enq_idx !== 6'd0) begin miscompares++; $display("FAIL reset_enq_idx got %0d exp 0", io_enq_idx); end
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            io_enq_valid = 1'b1;
            io_enq_data  = DATA_W'(i);
            #1;
            vectors++; if (io_enq_idx !== IDX_W'(i) || io_enq_ready !== 1'b1 || mem_W0_en !== 1'b1 || mem_W0_addr !== IDX_W'(i))
                begin miscompares++; $display("FAIL fill_idx[%0d] got idx %0d rdy %b wen %b exp idx %0d rdy 1 wen 1", i, io_enq_idx, io_enq_ready, mem_W0_en, i); end
            tick();
        end
        io_enq_data = DATA_W'(72'hDEAD);
        #1;
        vectors++; if (io_full !== 1'b1) begin miscompares++; $display("FAIL fill_full got %b exp 1", io_full); end
        vectors++; if (io_enq_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready got %b exp 0", io_enq_ready); end
        vectors++; if (mem_W0_en !== 1'b0) begin miscompares++; $display("FAIL fill_41st_wen got %b exp 0", mem_W0_en); end
        vectors++; if (io_empty !== 1'b0) begin miscompares++; $display("FAIL fill_empty got %b exp 0", io_empty); end
        tick();
        io_enq_valid = 1'b0;
        io_rd_valid  = 1'b1;
        io_rd_idx    = 6'd0;
        tick();
        io_rd_valid = 1'b0;
        #1;
        vectors++; if (io_rd_resp_valid !== 1'b1 || io_rd_resp_data !== 72'd0)
            begin miscompares++; $display("FAIL fill_slot0_kept got v %b data %h exp v 1 data 0", io_rd_resp_valid, io_rd_resp_data); end
    endtask

    task automatic test_full_deq_enq();
        io_deq_valid = 1'b1;
        io_enq_valid = 1'b1;
        io_enq_data  = 72'd100;
        #1;
        vectors++; if (io_enq_ready !== 1'b0 || mem_W0_en !== 1'b0)
            begin miscompares++; $display("FAIL fulldq_enq_refused got rdy %b wen %b exp 0 0", io_enq_ready, mem_W0_en); end
        tick();
        io_deq_valid = 1'b0;
        #1;
        vectors++; if (io_full !== 1'b0 || io_enq_ready !== 1'b1)
            begin miscompares++; $display("FAIL fulldq_count39 got full %b rdy %b exp 0 1", io_full, io_enq_ready); end
        vectors++; if (io_enq_idx !== 6'd0) begin miscompares++; $display("FAIL fulldq_wrap_idx got %0d exp 0", io_enq_idx); end
        tick();
        io_enq_valid = 1'b0;
        io_rd_valid  = 1'b1;
        io_rd_idx    = 6'd0;
        #1;
        vectors++; if (io_full !== 1'b1 || io_enq_idx !== 6'd1)
            begin miscompares++; $display("FAIL fulldq_refull got full %b idx %0d exp 1 1", io_full, io_enq_idx); end
        tick();
        io_rd_valid = 1'b0;
        #1;
        vectors++; if (io_rd_resp_data !== 72'd100)
            begin miscompares++; $display("FAIL fulldq_wrap_data got %h exp %h", io_rd_resp_data, 72'd100); end
    endtask

    task automatic test_redirect();
        do_reset();
        tick();
        enq_n(10, 200);
        io_redirect_valid = 1'b1;
        io_redirect_idx   = 6'd4;
        io_enq_valid      = 1'b1;
        #1;
        vectors++; if (io_enq_ready !== 1'b0 || mem_W0_en !== 1'b0)
            begin miscompares++; $display("FAIL redir_blocks_enq got rdy %b wen %b exp 0 0", io_enq_ready, mem_W0_en); end
        tick();
        idle();
        #1;
        vectors++; if (io_enq_idx !== 6'd5) begin miscompares++; $display("FAIL redir_enq_idx got %0d exp 5", io_enq_idx); end
        for (int i = 0; i < 5; i++) begin
            vectors++; if (io_empty !== 1'b0) begin miscompares++; $display("FAIL redir_count5[%0d] empty got %b exp 0", i, io_empty); end
            io_deq_valid = 1'b1;
            tick();
        end
        io_deq_valid = 1'b0;
        #1;
        vectors++; if (io_empty !== 1'b1) begin miscompares++; $display("FAIL redir_drained empty got %b exp 1", io_empty); end
    endtask

    task automatic test_redirect_deq();
        do_reset();
        tick();
        enq_n(10, 400);
        io_redirect_valid = 1'b1;
        io_redirect_idx   = 6'd4;
        io_deq_valid      = 1'b1;
        tick();
        idle();
        #1;
        vectors++; if (io_enq_idx !== 6'd5) begin miscompares++; $display("FAIL redirdq_enq_idx got %0d exp 5", io_enq_idx); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (io_empty !== 1'b0) begin miscompares++; $display("FAIL redirdq_count4[%0d] empty got %b exp 0", i, io_empty); end
            io_deq_valid = 1'b1;
            tick();
        end
        io_deq_valid = 1'b0;
        #1;
        vectors++; if (io_empty !== 1'b1) begin miscompares++; $display("FAIL redirdq_drained empty got %b exp 1", io_empty); end
    endtask

    task automatic test_read_bypass();
        do_reset();
        tick();
        enq_n(3, 300);
        io_enq_valid = 1'b1;
        io_enq_data  = {9{8'hA5}};
        io_rd_valid  = 1'b1;
        io_rd_idx    = 6'd3;
        #1;
        vectors++; if (mem_R0_en !== 1'b1 || mem_R0_addr !== 6'd3 || mem_W0_addr !== 6'd3)
            begin miscompares++; $display("FAIL bypass_ports got ren %b raddr %0d waddr %0d exp 1 3 3", mem_R0_en, mem_R0_addr, mem_W0_addr); end
        tick();
        idle();
        #1;
        vectors++; if (io_rd_resp_valid !== 1'b1 || io_rd_resp_data !== {9{8'hA5}})
            begin miscompares++; $display("FAIL bypass_data got v %b data %h exp 1 a5..a5", io_rd_resp_valid, io_rd_resp_data); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_d [0:3];
        exp_d[0] = 72'd300;
        exp_d[1] = 72'd301;
        exp_d[2] = 72'd302;
        exp_d[3] = {9{8'hA5}};
        for (int i = 3; i >= 0; i--) begin
            io_rd_valid = 1'b1;
            io_rd_idx   = IDX_W'(i);
            tick();
            vectors++; if (io_rd_resp_valid !== 1'b1 || io_rd_resp_data !== exp_d[i])
                begin miscompares++; $display("FAIL b2b_read[%0d] got v %b data %h exp 1 %h", i, io_rd_resp_valid, io_rd_resp_data, exp_d[i]); end
        end
        io_rd_valid = 1'b0;
        tick();
        vectors++; if (io_rd_resp_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got %b exp 0", io_rd_resp_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick();
        enq_n(7, 500);
        io_rd_valid = 1'b1;
        io_rd_idx   = 6'd2;
        tick();
        io_rd_valid = 1'b0;
        #1;
        vectors++; if (io_empty !== 1'b0 || io_rd_resp_valid !== 1'b1)
            begin miscompares++; $display("FAIL areset_pre got empty %b v %b exp 0 1", io_empty, io_rd_resp_valid); end
        reset = 1'b1;
        #1;
        vectors++; if (io_empty !== 1'b1 || io_rd_resp_valid !== 1'b0)
            begin miscompares++; $display("FAIL areset_immediate got empty %b v %b exp 1 0", io_empty, io_rd_resp_valid); end
        #1;
        reset = 1'b0;
        io_enq_valid = 1'b1;
        io_enq_data  = 72'd77;
        #1;
        vectors++; if (io_enq_idx !== 6'd0 || mem_W0_en !== 1'b1)
            begin miscompares++; $display("FAIL areset_first_idx got idx %0d wen %b exp 0 1", io_enq_idx, mem_W0_en); end
        tick();
        io_enq_valid = 1'b0;
        #1;
        vectors++; if (io_empty !== 1'b0 || io_enq_idx !== 6'd1)
            begin miscompares++; $display("FAIL areset_after_enq got empty %b idx %0d exp 0 1", io_empty, io_enq_idx); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_deq_enq();
        test_redirect();
        test_redirect_deq();
        test_read_bypass();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ghist_queue_ctrl.md
Name: ghist_queue_ctrl

Overview:
- Control stage directly in front of the 40-entry x 72-bit global-history snapshot memory used by the fetch target queue.
- Allocates history slots in order at fetch and frees them in order at commit.
- Rolls the allocation pointer back on a frontend redirect.
- Issues indexed history reads and returns the result one cycle later.
- Drives the memory's R0/W0 ports directly; the memory itself sits outside this block.

Parameters:
- DEPTH, 40, number of history entries; pointers wrap at DEPTH-1 to 0 (not a power of two).
- IDX_W, 6, pointer/index width.
- DATA_W, 72, history snapshot width.

Ports:
- clock  input  1  single clock for all state and the memory ports.
- reset  input  1  asynchronous, active-high reset.
- io_enq_valid  input  1  fetch offers a history snapshot.
- io_enq_ready  output  1  slot available and no redirect this cycle.
- io_enq_data  input  DATA_W  snapshot to store.
- io_enq_idx  output  IDX_W  slot index an accepted enqueue is written to (current enq_ptr).
- io_deq_valid  input  1  commit frees the oldest entry.
- io_redirect_valid  input  1  squash all entries younger than io_redirect_idx.
- io_redirect_idx  input  IDX_W  last surviving entry.
- io_rd_valid  input  1  read request.
- io_rd_idx  input  IDX_W  entry to read.
- io_rd_resp_valid  output  1  read data valid, one cycle after the request.
- io_rd_resp_data  output  DATA_W  read data (pass-through of mem_R0_data).
- io_empty  output  1  count == 0.
- io_full  output  1  count == DEPTH.
- mem_R0_addr  output  IDX_W  equals io_rd_idx.
- mem_R0_en  output  1  equals io_rd_valid.
- mem_R0_data  input  DATA_W  memory read data.
- mem_W0_addr  output  IDX_W  equals enq_ptr.
- mem_W0_en  output  1  enqueue fire.
- mem_W0_data  output  DATA_W  equals io_enq_data.

Behaviour:
- State:
  - enq_ptr, deq_ptr: IDX_W bits each.
  - count: 0..DEPTH, 6 bits.
  - resp_v: 1 bit.
- Reset (async, active-high): enq_ptr=0, deq_ptr=0, count=0, resp_v=0. Therefore io_empty=1, io_full=0, io_enq_ready=1, io_rd_resp_valid=0.
- Increment rule: inc(p) = (p==DEPTH-1) ? 0 : p+1. All pointer arithmetic is modulo DEPTH.
- Enqueue:
  - io_enq_ready = !io_full && !io_redirect_valid.
  - fire = io_enq_valid && io_enq_ready.
  - On fire: the memory write happens the same cycle at enq_ptr, and enq_ptr <= inc(enq_ptr).
- Dequeue:
  - deq_fire = io_deq_valid && !io_empty.
  - On deq_fire: deq_ptr <= inc(deq_ptr).
  - io_deq_valid when empty is ignored (no state change).
- Count update (no redirect):
  - count += fire - deq_fire.
  - Enqueue and dequeue in the same cycle leave count unchanged. This is legal when full only if no enqueue fires; ready is already low when full.
- Redirect:
  - Takes priority over enqueue, which is blocked that cycle.
  - enq_ptr <= inc(io_redirect_idx).
  - dnext = deq_fire ? inc(deq_ptr) : deq_ptr.
  - count <= ((io_redirect_idx - dnext + DEPTH) mod DEPTH) + 1.
  - A deq_fire in the same cycle still applies.
  - io_redirect_idx must lie in the live range [dnext .. enq_ptr-1]. Violation is a simulation assertion error; the RTL result is undefined.
- Reads:
  - mem_R0_en/addr are driven combinationally from io_rd_*.
  - resp_v <= io_rd_valid; io_rd_resp_valid = resp_v; io_rd_resp_data = mem_R0_data.
  - Latency is exactly 1 cycle, with back-to-back reads every cycle.
  - A read of a slot written in the request cycle returns the new data, because the memory latches the address and writes on the same edge.
  - Reads of non-live slots are allowed; the returned data is stale and carries no error.
- Reset asserted mid-operation clears all pointers immediately. Memory contents are not cleared and are treated as invalid.

Optional Feature:
- GHIST_OCC_STATS_EN defined:
  - Adds output io_count (6 bits, equals count).
  - Adds output io_hiwater (6 bits): maximum count since reset, reset value 0, updated every cycle to max(hiwater, count_next).
- Not defined: neither port nor register exists; the behaviour is otherwise identical.

Test Plan:
- Reset, then 40 back-to-back enqueues with data=i -> io_enq_idx steps 0..39, io_full=1 after the 40th, io_enq_ready=0, the 41st offer is not written.
- From full, one deq plus one enq in the same cycle -> io_enq_ready is already 0, so the enq is refused and count becomes 39. On the next cycle the enq goes to idx 0 (wrap) and count returns to 40.
- Enqueue 10 entries (idx 0..9), then redirect with idx=4 and io_enq_valid=1 -> enq not accepted, next io_enq_idx=5, count=5.
- Redirect idx=4 with deq_fire in the same cycle, deq_ptr=0 -> deq_ptr=1, count=4, enq_ptr=5.
- Write 0xA5..A5 to idx 3 and read idx 3 in the same cycle -> next cycle io_rd_resp_valid=1, data=0xA5..A5. Reads on consecutive cycles return 1-cycle-delayed responses each cycle.
- Assert reset asynchronously (between edges) while count=7 -> io_empty=1 and io_rd_resp_valid=0 immediately. After release, the first enqueue gets idx 0.
